// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and slice width.
package nibble_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned SLICE_W = 4;

endpackage

// File: rtl/nibble_serial_adder_csa4.sv
// Combinational 4-bit carry-skip adder slice, time-multiplexed by the serial adder.
module csa4_slice
    import nibble_serial_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co,
    output logic               skip,
    output logic               c3
);

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W:0]   c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        c[0] = ci;
        for (int unsigned i = 0; i < SLICE_W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        s    = p ^ c[SLICE_W-1:0];
        skip = &p;
        // With every bit propagating, the slice carry-in is forwarded directly.
        co   = skip ? ci : c[SLICE_W];
        c3   = c[SLICE_W-1];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit carry-skip slice reused over WIDTH/4 cycles, valid/ready on both sides.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  a,
    input  logic [WIDTH-1:0]                  b,
    input  logic                              cin,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WIDTH-1:0]                  sum,
    output logic                              cout,
    output logic                              ovf,
    output logic [$clog2(WIDTH/4+1)-1:0]      skips
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int unsigned SKW = $clog2(NIB + 1);
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry;
    logic [IW-1:0]      idx;

    logic [SLICE_W-1:0] sl_a;
    logic [SLICE_W-1:0] sl_b;
    logic [SLICE_W-1:0] sl_s;
    logic               sl_co;
    logic               sl_skip;
    logic               sl_c3;

    assign sl_a = a_q[idx*SLICE_W +: SLICE_W];
    assign sl_b = b_q[idx*SLICE_W +: SLICE_W];

    csa4_slice u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .ci   (carry),
        .s    (sl_s),
        .co   (sl_co),
        .skip (sl_skip),
        .c3   (sl_c3)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            skips     <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry    <= cin;
                        idx      <= '0;
                        sum      <= '0;
                        skips    <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum[idx*SLICE_W +: SLICE_W] <= sl_s;
                    carry <= sl_co;
                    if (sl_skip) begin
                        skips <= skips + SKW'(1);
                    end
                    // Index stops at the last slice; leaving RUN replaces the wrap.
                    if (idx == LAST) begin
                        cout      <= sl_co;
                        ovf       <= sl_c3 ^ sl_co;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [2:0]  skips;

    int n_checks;
    int n_fail;
    int cyc;
    int t0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .skips     (skips)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present operands in IDLE; the next edge accepts them.
    task automatic issue(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        a        = va;
        b        = vb;
        cin      = vc;
        in_valid = 1'b1;
        step();
        chk("accept_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        cin      = 1'b1;
        step();
        step();
        step();
        chk("latency_not_yet", {31'd0, out_valid}, 32'd0);
        step();
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a         = 16'h1234;
        b         = 16'h5678;
        cin       = 1'b1;
        step();
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_skips", {29'd0, skips}, 32'd0);

        // Carry chain through bypassed upper nibbles, then backpressure.
        issue(16'hFFFF, 16'h0001, 1'b0);
        chk("chain_sum", {16'd0, sum}, 32'h0000);
        chk("chain_cout", {31'd0, cout}, 32'd1);
        chk("chain_ovf", {31'd0, ovf}, 32'd0);
        chk("chain_skips", {29'd0, skips}, 32'd3);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_sum", {16'd0, sum}, 32'h0000);
            chk("bp_cout", {31'd0, cout}, 32'd1);
            chk("bp_skips", {29'd0, skips}, 32'd3);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);
        chk("release_out_valid", {31'd0, out_valid}, 32'd0);

        // Signed overflow.
        issue(16'h7FFF, 16'h0001, 1'b0);
        chk("ovf_sum", {16'd0, sum}, 32'h8000);
        chk("ovf_cout", {31'd0, cout}, 32'd0);
        chk("ovf_ovf", {31'd0, ovf}, 32'd1);
        chk("ovf_skips", {29'd0, skips}, 32'd2);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Carry-in forwarded across every slice.
        issue(16'h0F0F, 16'hF0F0, 1'b1);
        chk("bypass_sum", {16'd0, sum}, 32'h0000);
        chk("bypass_cout", {31'd0, cout}, 32'd1);
        chk("bypass_ovf", {31'd0, ovf}, 32'd0);
        chk("bypass_skips", {29'd0, skips}, 32'd4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset during the second RUN cycle.
        a        = 16'hAAAA;
        b        = 16'h5555;
        cin      = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_sum", {16'd0, sum}, 32'h0000);
        issue(16'h1234, 16'h1111, 1'b0);
        chk("after_abort_sum", {16'd0, sum}, 32'h2345);
        chk("after_abort_cout", {31'd0, cout}, 32'd0);
        chk("after_abort_skips", {29'd0, skips}, 32'd0);

        // Back-to-back with in_valid held and out_ready high.
        out_ready = 1'b1;
        step();
        a        = 16'h0001;
        b        = 16'h0002;
        cin      = 1'b0;
        in_valid = 1'b1;
        step();
        t0 = cyc;
        chk("b2b_first_accept", {31'd0, in_ready}, 32'd0);
        a = 16'h00F0;
        b = 16'h0F00;
        for (int k = 0; k < 20 && out_valid !== 1'b1; k++) step();
        chk("b2b_first_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_first_latency", cyc - t0, 32'd4);
        chk("b2b_first_sum", {16'd0, sum}, 32'h0003);
        for (int k = 0; k < 20 && in_ready !== 1'b1; k++) step();
        chk("b2b_idle", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 20 && in_ready !== 1'b0; k++) step();
        chk("b2b_second_accept", {31'd0, in_ready}, 32'd0);
        chk("b2b_interval", cyc - t0, 32'd6);
        in_valid = 1'b0;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        for (int k = 0; k < 20 && out_valid !== 1'b1; k++) step();
        chk("b2b_second_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_second_sum", {16'd0, sum}, 32'h0FF0);
        chk("b2b_second_skips", {29'd0, skips}, 32'd2);
        step();
        chk("b2b_final_idle", {31'd0, in_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
